gelato_simt_stack: RTL and testbench
====================================

# gelato_simt_stack

Parametrised per-warp SIMT reconvergence stack for the Gelato frontend. It generalises the fixed per-warp split table: warp count, thread count, stack depth and PC width are all configurable. Each stack entry carries an active-thread mask, and the block supports two-way divergence, automatic reconvergence pops, warp launch and exit. The block sits between instruction decode, which issues stack updates, and the fetch scheduler, which reads the top-of-stack PC and mask for each warp.

## Interface
- WARP_NUM, 4, number of warps, each with its own stack
- THREAD_NUM, 32, threads per warp; this is the mask width
- DEPTH, 8, stack entries per warp (≥2)
- PC_WIDTH, 32, PC width in bits

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, all state holds and all inputs are ignored
- launch_valid  in  1  start a warp
- launch_warp  in  $clog2(WARP_NUM)  warp index to launch
- launch_pc  in  PC_WIDTH  entry PC for the launched warp
- launch_mask  in  THREAD_NUM  initial active mask
- upd_valid  in  1  stack update from decode
- upd_warp  in  $clog2(WARP_NUM)  target warp
- upd_op  in  2  operation: 0 ADVANCE, 1 SPLIT, 2 EXIT, 3 reserved (no-op)
- upd_next_pc  in  PC_WIDTH  next PC for ADVANCE, fallthrough PC for SPLIT
- upd_taken_pc  in  PC_WIDTH  branch target for SPLIT
- upd_reconv_pc  in  PC_WIDTH  reconvergence PC for SPLIT
- upd_taken_mask  in  THREAD_NUM  per-thread branch outcome
- sel_valid  out  WARP_NUM  warp has depth > 0
- sel_pc  out  WARP_NUM×PC_WIDTH  top-of-stack PC
- sel_mask  out  WARP_NUM×THREAD_NUM  top-of-stack active mask
- sel_depth  out  WARP_NUM×$clog2(DEPTH+1)  current stack depth
- overflow  out  WARP_NUM  sticky per-warp overflow flag

## Operation
- Each entry is {pc, rpc, mask}. The top entry is entry[depth-1]. Define RPC_NONE = all ones.
- **LAUNCH:**
  - Sets depth to 1, entry0 to {launch_pc, RPC_NONE, launch_mask}, and clears overflow.
  - LAUNCH is accepted in any state.
- **Updates to a warp with depth 0** are ignored.
- **ADVANCE:**
  - If depth > 1 and upd_next_pc == top.rpc, pop: depth−1.
  - Otherwise top.pc ← upd_next_pc.
  - The entry exposed by a pop already holds pc = reconv PC. At most one pop per cycle.
- **SPLIT:** let A = top.mask, T = A & upd_taken_mask, F = A & ~upd_taken_mask.
  - T == 0: top.pc ← upd_next_pc.
  - F == 0: top.pc ← upd_taken_pc.
  - Otherwise the warp diverges:
    - Normal case: top.pc ← upd_reconv_pc. Push {upd_next_pc, upd_reconv_pc, F}, then push {upd_taken_pc, upd_reconv_pc, T}. Depth +2. The taken path executes first.
    - Collapse case: if depth > 1 and upd_reconv_pc == top.rpc, the top entry is replaced by the F entry and only the T entry is pushed. Depth +1.
  - Overflow: if the required depth exceeds DEPTH, set overflow[w]. The stack is unchanged.
- **EXIT:** pop the top entry. If depth becomes 0, the warp is invalid (sel_valid = 0).
- **LAUNCH and update to the same warp in the same cycle:** LAUNCH wins and the update is dropped. A LAUNCH and an update to different warps both take effect.
- **Reserved op:** no state change.

## Timing
- Reset values: all depths 0, sel_valid 0, sel_pc 0, sel_mask 0, sel_depth 0, overflow 0. Entry RAM contents are don't-care; outputs are gated by depth.
- Outputs are registered and driven directly from the top entry and depth state.
- Latency: an update or launch in cycle N is visible on sel_* in cycle N+1.
- There is no backpressure. At most one update and one launch per cycle, and every accepted input completes in one cycle.
- rdy low: nothing changes, including overflow.
- Reset asserted mid-operation: all warps return to depth 0 immediately (asynchronous).
- Depth arithmetic is unsigned at $clog2(DEPTH+1) bits. The overflow check runs before any write, so no wrap-around can occur.

## Test plan
- **Launch:** launch warp 1, pc 0x100, mask 0xFFFFFFFF → next cycle sel_valid = 0010, sel_pc[1] = 0x100, sel_depth[1] = 1.
- **ADVANCE chain:** ADVANCE warp 1 to 0x104, then 0x108 → sel_pc[1] follows one cycle later. Depth stays 1 (rpc is RPC_NONE).
- **Divergence and reconvergence:**
  - SPLIT with taken_mask 0x0000FFFF, taken 0x200, next 0x110, reconv 0x300 → depth 3, pc 0x200, mask 0x0000FFFF.
  - ADVANCE to 0x300 → depth 2, pc 0x110, mask 0xFFFF0000.
  - ADVANCE to 0x300 → depth 1, pc 0x300, mask 0xFFFFFFFF.
- **Uniform branches:** taken_mask 0 → only the pc changes, to next. taken_mask covering the full active mask → pc changes to taken. Depth unchanged in both.
- **Nested collapse and overflow:**
  - Nested SPLIT with reconv equal to the current top.rpc → depth +1 only.
  - With DEPTH = 4, issue splits until a push would exceed 4 → overflow[w] = 1 and the stack is unchanged. A subsequent launch clears the flag.
- **Exit and collisions:**
  - EXIT at depth 1 → sel_valid bit cleared, and later updates to that warp are ignored.
  - Simultaneous launch and SPLIT to the same warp → launch state only.
  - Hold rdy low for 3 cycles while issuing updates → no change.
  - Assert rst_n low mid-divergence → all outputs 0.

Source files
------------

// File: rtl/gelato_simt_stack_if.sv
// Decode/launch request bus into the SIMT stack and the per-warp top-of-stack view
// returned to the fetch scheduler.
interface gelato_simt_stack_if #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32
);
  localparam int WW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
  localparam int DW = $clog2(DEPTH + 1);

  logic                                launch_valid;
  logic [WW-1:0]                       launch_warp;
  logic [PC_WIDTH-1:0]                 launch_pc;
  logic [THREAD_NUM-1:0]               launch_mask;
  logic                                upd_valid;
  logic [WW-1:0]                       upd_warp;
  logic [1:0]                          upd_op;
  logic [PC_WIDTH-1:0]                 upd_next_pc;
  logic [PC_WIDTH-1:0]                 upd_taken_pc;
  logic [PC_WIDTH-1:0]                 upd_reconv_pc;
  logic [THREAD_NUM-1:0]               upd_taken_mask;
  logic [WARP_NUM-1:0]                 sel_valid;
  logic [WARP_NUM-1:0][PC_WIDTH-1:0]   sel_pc;
  logic [WARP_NUM-1:0][THREAD_NUM-1:0] sel_mask;
  logic [WARP_NUM-1:0][DW-1:0]         sel_depth;
  logic [WARP_NUM-1:0]                 overflow;

  modport master (
    output launch_valid, launch_warp, launch_pc, launch_mask,
    output upd_valid, upd_warp, upd_op, upd_next_pc, upd_taken_pc, upd_reconv_pc, upd_taken_mask,
    input  sel_valid, sel_pc, sel_mask, sel_depth, overflow
  );

  modport slave (
    input  launch_valid, launch_warp, launch_pc, launch_mask,
    input  upd_valid, upd_warp, upd_op, upd_next_pc, upd_taken_pc, upd_reconv_pc, upd_taken_mask,
    output sel_valid, sel_pc, sel_mask, sel_depth, overflow
  );
endinterface

// File: rtl/gelato_simt_stack.sv
// Per-warp SIMT reconvergence stack: launch, advance with automatic reconvergence pop,
// two-way split (with nested-collapse), exit, and sticky overflow detection.
module gelato_simt_stack #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  gelato_simt_stack_if.slave  bus
);
  localparam int WW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
  localparam int DW = $clog2(DEPTH + 1);
  localparam int XW = DW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_ADVANCE = 2'd0;
  localparam logic [1:0] OP_SPLIT   = 2'd1;
  localparam logic [1:0] OP_EXIT    = 2'd2;
  localparam logic [PC_WIDTH-1:0] RPC_NONE = '1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   rpc;
    logic [THREAD_NUM-1:0] mask;
  } entry_t;

  entry_t                              mem_r [WARP_NUM][DEPTH];
  logic [DW-1:0]                       depth_r [WARP_NUM];
  logic [WARP_NUM-1:0]                 overflow_r;
  logic [WARP_NUM-1:0]                 sel_valid_r;
  logic [WARP_NUM-1:0][PC_WIDTH-1:0]   sel_pc_r;
  logic [WARP_NUM-1:0][THREAD_NUM-1:0] sel_mask_r;
  logic [WARP_NUM-1:0][DW-1:0]         sel_depth_r;

  entry_t              wr_s    [WARP_NUM][3];
  logic [AW-1:0]       wi_s    [WARP_NUM][3];
  logic [2:0]          we_s    [WARP_NUM];
  logic [DW-1:0]       nd_s    [WARP_NUM];
  entry_t              top_n_s [WARP_NUM];
  logic [WARP_NUM-1:0] ovf_set_s;
  logic [WARP_NUM-1:0] ovf_clr_s;

  // Per-warp next state: up to three entry writes, new depth, overflow update, next top entry
  always_comb begin
    logic [DW-1:0]         d_v;
    logic [XW-1:0]         dx_v;
    logic [AW-1:0]         t_v;
    logic [AW-1:0]         nt_v;
    entry_t                top_v;
    logic [THREAD_NUM-1:0] tk_v;
    logic [THREAD_NUM-1:0] ft_v;
    logic                  l_hit_v;
    logic                  u_hit_v;
    logic                  collapse_v;
    for (int w = 0; w < WARP_NUM; w++) begin
      d_v        = depth_r[w];
      dx_v       = {1'b0, d_v};
      t_v        = AW'(d_v - DW'(1));
      top_v      = mem_r[w][t_v];
      tk_v       = top_v.mask & bus.upd_taken_mask;
      ft_v       = top_v.mask & ~bus.upd_taken_mask;
      l_hit_v    = bus.launch_valid && (bus.launch_warp == WW'(w));
      u_hit_v    = bus.upd_valid && (bus.upd_warp == WW'(w)) && !l_hit_v && (d_v != DW'(0));
      collapse_v = (d_v > DW'(1)) && (bus.upd_reconv_pc == top_v.rpc);
      we_s[w]      = 3'b000;
      nd_s[w]      = d_v;
      ovf_set_s[w] = 1'b0;
      ovf_clr_s[w] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        wr_s[w][k] = top_v;
        wi_s[w][k] = t_v;
      end
      if (l_hit_v) begin
        we_s[w]      = 3'b001;
        wi_s[w][0]   = '0;
        wr_s[w][0]   = '{pc: bus.launch_pc, rpc: RPC_NONE, mask: bus.launch_mask};
        nd_s[w]      = DW'(1);
        ovf_clr_s[w] = 1'b1;
      end else if (u_hit_v) begin
        case (bus.upd_op)
          OP_ADVANCE: begin
            if ((d_v > DW'(1)) && (bus.upd_next_pc == top_v.rpc)) begin
              nd_s[w] = d_v - DW'(1);
            end else begin
              we_s[w]       = 3'b001;
              wr_s[w][0].pc = bus.upd_next_pc;
            end
          end
          OP_SPLIT: begin
            if (tk_v == '0) begin
              we_s[w]       = 3'b001;
              wr_s[w][0].pc = bus.upd_next_pc;
            end else if (ft_v == '0) begin
              we_s[w]       = 3'b001;
              wr_s[w][0].pc = bus.upd_taken_pc;
            end else if (collapse_v) begin
              // Nested split sharing the enclosing reconv PC: fallthrough replaces the top
              if ((dx_v + XW'(1)) > XW'(DEPTH)) begin
                ovf_set_s[w] = 1'b1;
              end else begin
                we_s[w]    = 3'b011;
                wr_s[w][0] = '{pc: bus.upd_next_pc, rpc: bus.upd_reconv_pc, mask: ft_v};
                wi_s[w][1] = AW'(d_v);
                wr_s[w][1] = '{pc: bus.upd_taken_pc, rpc: bus.upd_reconv_pc, mask: tk_v};
                nd_s[w]    = d_v + DW'(1);
              end
            end else begin
              if ((dx_v + XW'(2)) > XW'(DEPTH)) begin
                ovf_set_s[w] = 1'b1;
              end else begin
                we_s[w]       = 3'b111;
                wr_s[w][0].pc = bus.upd_reconv_pc;
                wi_s[w][1]    = AW'(d_v);
                wr_s[w][1]    = '{pc: bus.upd_next_pc, rpc: bus.upd_reconv_pc, mask: ft_v};
                wi_s[w][2]    = AW'(d_v + DW'(1));
                wr_s[w][2]    = '{pc: bus.upd_taken_pc, rpc: bus.upd_reconv_pc, mask: tk_v};
                nd_s[w]       = d_v + DW'(2);
              end
            end
          end
          OP_EXIT: begin
            nd_s[w] = d_v - DW'(1);
          end
          default: begin
            nd_s[w] = d_v;
          end
        endcase
      end else begin
        nd_s[w] = d_v;
      end
      // New top comes from this cycle's writes if one lands there, else from the RAM
      nt_v       = AW'(nd_s[w] - DW'(1));
      top_n_s[w] = mem_r[w][nt_v];
      for (int k = 0; k < 3; k++) begin
        if (we_s[w][k] && (wi_s[w][k] == nt_v)) begin
          top_n_s[w] = wr_s[w][k];
        end else begin
          top_n_s[w] = top_n_s[w];
        end
      end
    end
  end

  // Entry RAM writes; contents are don't-care while a warp is inactive
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        for (int k = 0; k < 3; k++) begin
          if (we_s[w][k]) begin
            mem_r[w][wi_s[w][k]] <= wr_s[w][k];
          end
        end
      end
    end
  end

  // Depth, sticky overflow and registered top-of-stack outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= '0;
      sel_valid_r <= '0;
      sel_pc_r    <= '0;
      sel_mask_r  <= '0;
      sel_depth_r <= '0;
      for (int w = 0; w < WARP_NUM; w++) begin
        depth_r[w] <= '0;
      end
    end else if (rdy) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        depth_r[w]     <= nd_s[w];
        overflow_r[w]  <= (overflow_r[w] | ovf_set_s[w]) & ~ovf_clr_s[w];
        sel_valid_r[w] <= (nd_s[w] != DW'(0));
        sel_pc_r[w]    <= (nd_s[w] != DW'(0)) ? top_n_s[w].pc : '0;
        sel_mask_r[w]  <= (nd_s[w] != DW'(0)) ? top_n_s[w].mask : '0;
        sel_depth_r[w] <= nd_s[w];
      end
    end
  end

  assign bus.sel_valid = sel_valid_r;
  assign bus.sel_pc    = sel_pc_r;
  assign bus.sel_mask  = sel_mask_r;
  assign bus.sel_depth = sel_depth_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_gelato_simt_stack.sv
// Directed table-driven bench for gelato_simt_stack (DEPTH = 4 to reach overflow quickly).
module tb_gelato_simt_stack;
  localparam int WN = 4;
  localparam int TN = 32;
  localparam int DP = 4;
  localparam int PW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rdy   = 1'b1;
  always #5 clk = ~clk;

  gelato_simt_stack_if #(.WARP_NUM(WN), .THREAD_NUM(TN), .DEPTH(DP), .PC_WIDTH(PW)) bus ();
  gelato_simt_stack #(.WARP_NUM(WN), .THREAD_NUM(TN), .DEPTH(DP), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus)
  );

  typedef struct {
    logic        lv;
    logic [1:0]  lw;
    logic [31:0] lpc;
    logic [31:0] lmask;
    logic        uv;
    logic [1:0]  uw;
    logic [1:0]  op;
    logic [31:0] nx;
    logic [31:0] tk;
    logic [31:0] rc;
    logic [31:0] tm;
    logic [1:0]  cw;
    logic [3:0]  ev;
    logic [31:0] epc;
    logic [31:0] emask;
    logic [2:0]  ed;
    logic [3:0]  eo;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic lv, logic [1:0] lw, logic [31:0] lpc, logic [31:0] lmask,
                              logic uv, logic [1:0] uw, logic [1:0] op, logic [31:0] nx,
                              logic [31:0] tk, logic [31:0] rc, logic [31:0] tm,
                              logic [1:0] cw, logic [3:0] ev, logic [31:0] epc,
                              logic [31:0] emask, logic [2:0] ed, logic [3:0] eo);
    vec_t v;
    v.lv = lv; v.lw = lw; v.lpc = lpc; v.lmask = lmask;
    v.uv = uv; v.uw = uw; v.op = op; v.nx = nx; v.tk = tk; v.rc = rc; v.tm = tm;
    v.cw = cw; v.ev = ev; v.epc = epc; v.emask = emask; v.ed = ed; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.launch_valid   = v.lv;
    bus.launch_warp    = v.lw;
    bus.launch_pc      = v.lpc;
    bus.launch_mask    = v.lmask;
    bus.upd_valid      = v.uv;
    bus.upd_warp       = v.uw;
    bus.upd_op         = v.op;
    bus.upd_next_pc    = v.nx;
    bus.upd_taken_pc   = v.tk;
    bus.upd_reconv_pc  = v.rc;
    bus.upd_taken_mask = v.tm;
  endtask

  task automatic check(string tag, vec_t v);
    chk({tag, ".valid"}, 32'(bus.sel_valid), 32'(v.ev));
    chk({tag, ".pc"},    bus.sel_pc[v.cw], v.epc);
    chk({tag, ".mask"},  bus.sel_mask[v.cw], v.emask);
    chk({tag, ".depth"}, 32'(bus.sel_depth[v.cw]), 32'(v.ed));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(v.eo));
  endtask

  task automatic step(string tag, vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(tag, v);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".valid"}, 32'(bus.sel_valid), 32'h0000_0000);
    chk({tag, ".pc"},    32'(|bus.sel_pc), 32'h0000_0000);
    chk({tag, ".mask"},  32'(|bus.sel_mask), 32'h0000_0000);
    chk({tag, ".depth"}, 32'(|bus.sel_depth), 32'h0000_0000);
    chk({tag, ".ovf"},   32'(bus.overflow), 32'h0000_0000);
  endtask

  localparam logic [1:0] ADV = 2'd0, SPL = 2'd1, EXT = 2'd2, RSV = 2'd3;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    vec_t v;
    // Columns: launch{v,w,pc,mask} update{v,w,op,next,taken,reconv,tmask} expect{warp,valid,pc,mask,depth,ovf}
    vecs.push_back(mk(1'b1,2'd1,32'h100,ALL, 1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0,           2'd1,4'b0010,32'h100,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h104,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h104,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h108,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h108,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h110,32'h200,32'h300,32'h0000FFFF, 2'd1,4'b0010,32'h200,32'h0000FFFF,3'd3,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h300,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h110,32'hFFFF0000,3'd2,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h300,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h300,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h304,32'h400,32'h500,32'h0,     2'd1,4'b0010,32'h304,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h308,32'h400,32'h500,ALL,       2'd1,4'b0010,32'h400,ALL,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h404,32'h600,32'h700,32'h00FF00FF, 2'd1,4'b0010,32'h600,32'h00FF00FF,3'd3,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h604,32'h800,32'h700,32'h0000000F, 2'd1,4'b0010,32'h800,32'h0000000F,3'd4,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,SPL,32'h804,32'h880,32'h900,32'h00000003, 2'd1,4'b0010,32'h800,32'h0000000F,3'd4,4'b0010));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h804,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h804,32'h0000000F,3'd4,4'b0010));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h700,32'h0,32'h0,32'h0,         2'd1,4'b0010,32'h604,32'h00FF00F0,3'd3,4'b0010));
    vecs.push_back(mk(1'b1,2'd1,32'h1000,32'h0000FFFF, 1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0, 2'd1,4'b0010,32'h1000,32'h0000FFFF,3'd1,4'b0000));
    vecs.push_back(mk(1'b1,2'd2,32'h2000,32'h0000FFFF, 1'b1,2'd1,ADV,32'h1004,32'h0,32'h0,32'h0, 2'd1,4'b0110,32'h1004,32'h0000FFFF,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0,           2'd2,4'b0110,32'h2000,32'h0000FFFF,3'd1,4'b0000));
    vecs.push_back(mk(1'b1,2'd1,32'h3000,32'hF0F0F0F0, 1'b1,2'd1,SPL,32'h3100,32'h4000,32'h5000,32'h0F0F0F0F, 2'd1,4'b0110,32'h3000,32'hF0F0F0F0,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,EXT,32'h0,32'h0,32'h0,32'h0,           2'd1,4'b0100,32'h0,32'h0,3'd0,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd1,ADV,32'h5000,32'h0,32'h0,32'h0,        2'd1,4'b0100,32'h0,32'h0,3'd0,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd2,RSV,32'h9999,32'h0,32'h0,32'h0,        2'd2,4'b0100,32'h2000,32'h0000FFFF,3'd1,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd3,SPL,32'h10,32'h20,32'h30,32'h0000FFFF, 2'd3,4'b0100,32'h0,32'h0,3'd0,4'b0000));
    vecs.push_back(mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd2,EXT,32'h0,32'h0,32'h0,32'h0,           2'd2,4'b0000,32'h0,32'h0,3'd0,4'b0000));

    drive(mk(1'b0,2'd0,32'h0,32'h0,1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0,2'd0,4'b0,32'h0,32'h0,3'd0,4'b0));
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // rdy low for three cycles: launch and update to warp 0 must both be ignored
    step("rdy_pre", mk(1'b1,2'd0,32'hA00,32'h000000FF, 1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0, 2'd0,4'b0001,32'hA00,32'h000000FF,3'd1,4'b0000));
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step($sformatf("rdy_low%0d", c), mk(1'b1,2'd0,32'hC00,32'h1, 1'b1,2'd0,SPL,32'hB00,32'hB80,32'hB90,32'h0F,
                                          2'd0,4'b0001,32'hA00,32'h000000FF,3'd1,4'b0000));
    end
    rdy = 1'b1;
    step("rdy_post", mk(1'b0,2'd0,32'h0,32'h0, 1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0, 2'd0,4'b0001,32'hA00,32'h000000FF,3'd1,4'b0000));

    // Diverge warp 0, then pull reset between clock edges
    step("div0", mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd0,SPL,32'hA04,32'hD00,32'hE00,32'h0000000F, 2'd0,4'b0001,32'hD00,32'h0000000F,3'd3,4'b0000));
    @(negedge clk);
    drive(mk(1'b0,2'd0,32'h0,32'h0,1'b0,2'd0,ADV,32'h0,32'h0,32'h0,32'h0,2'd0,4'b0,32'h0,32'h0,3'd0,4'b0));
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(1'b0,2'd0,32'h0,32'h0, 1'b1,2'd0,ADV,32'hA08,32'h0,32'h0,32'h0, 2'd0,4'b0000,32'h0,32'h0,3'd0,4'b0000);
    step("post_rst_upd", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
